intr_ctrl: RTL and testbench
============================

INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 The block SHALL have these ports, one clock, asynchronous active-low reset:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low; 0 = reset asserted
- readaddr  input  5  I/O read address
- readdata  output  8  registered read data
- writeaddr  input  5  I/O write address
- writedata  input  8  I/O write data
- write_en  input  1  write strobe, sampled at clk edge
- int_src  input  8  level interrupt lines from io_ctrl
- irq  output  1  interrupt request to CPU
- irq_vector  output  3  index of requested or in-service source
- irq_ack  input  1  CPU accepts request, single-cycle pulse
- irq_done  input  1  CPU return-from-interrupt, single-cycle pulse

REQ-002 Register map (package constants):
- ADDR_MASK = 5'd8, RW, reset 8'h00
- ADDR_PEND = 5'd9, R / write-1-to-clear
- ADDR_STAT = 5'd10, R: {state[1:0], 3'b0, irq_vector}

Function
REQ-003 The block SHALL register int_src every cycle as int_src_q (reset 0); rise[i] = int_src[i] & ~int_src_q[i].
REQ-004 The block SHALL set pend[i] at the edge where rise[i] is 1; pend is independent of mask.
REQ-005 A write to ADDR_PEND SHALL clear every pend bit whose writedata bit is 1.
REQ-006 If a set (rise) and a clear (write or ack) hit the same bit in the same cycle, set SHALL win.
REQ-007 A write to ADDR_MASK SHALL load mask <= writedata; mask[i]=1 enables source i.
REQ-008 readdata SHALL update one cycle after readaddr; unmapped addresses read 8'h00; ADDR_PEND and ADDR_STAT reads have no side effects.
REQ-009 The FSM SHALL have states IDLE=2'd0, REQ=2'd1, SERVICE=2'd2; 2'd3 is illegal and returns to IDLE.
REQ-010 In IDLE, if (pend & mask) != 0, the FSM SHALL move to REQ and latch irq_vector = lowest set index (bit 0 highest priority).
REQ-011 In REQ, irq SHALL be 1 and irq_vector SHALL stay stable until irq_ack, even if pend or mask changes.
REQ-012 On irq_ack in REQ, the FSM SHALL clear pend[irq_vector], deassert irq at the same edge, and enter SERVICE.
REQ-013 In SERVICE, irq SHALL be 0 and irq_vector SHALL hold the in-service index; no nesting is allowed.
REQ-014 On irq_done in SERVICE, the FSM SHALL enter IDLE; re-arbitration SHALL occur on the following cycle.
- Minimum gap between irq_done and the next irq rise: 1 cycle.
REQ-015 irq_ack outside REQ and irq_done outside SERVICE SHALL be ignored.
REQ-016 Latency: int_src rising before edge k SHALL set pend at edge k; irq SHALL be 1 after edge k+1 if the source is unmasked and the FSM is idle.
REQ-017 irq SHALL be a registered output, 1 only in REQ.

Reset
REQ-018 While reset=0, asynchronously:
- state = IDLE
- irq = 0
- irq_vector = 3'd0
- readdata = 8'h00
- mask, pend and int_src_q = 8'h00
REQ-019 Reset asserted mid-REQ or mid-SERVICE SHALL abandon the transaction; after release the block SHALL behave as freshly reset.
REQ-020 Lines already high at reset release SHALL NOT set pend until they fall and rise again.

Structure
REQ-021 Package intr_pkg SHALL hold the ADDR_* constants and the state encodings.
REQ-022 A combinational sub-module intr_prio_enc SHALL map an 8-bit input to {valid, index[2:0]}, lowest index winning.
REQ-023 All other logic SHALL be in intr_ctrl, a single clock domain, with no latches.

Verification
REQ-024 Directed scenarios:
- Basic request: mask=8'h01; pulse int_src[0] -> irq=1 two cycles later with irq_vector=0; irq_ack -> irq=0 and PEND reads 8'h00; irq_done -> STAT reads 8'h00.
- Priority: mask=8'hFF; raise int_src[5] and int_src[2] in the same cycle -> vector 2 first; after ack and done -> vector 5.
- Masking: mask=8'h00; pulse int_src[3] -> no irq and PEND=8'h08; write mask=8'h08 -> irq with vector 3.
- Set beats clear: rising int_src[1] in the same cycle as a PEND write of 8'h02 -> PEND bit 1 stays 1.
- Stray handshakes: irq_ack in IDLE and irq_done in REQ -> no state change; vector held stable in REQ while mask is cleared.
- Reset mid-operation: drive reset=0 during SERVICE -> irq=0, STAT=8'h00, mask=8'h00; int_src held high across release -> no new pend.

Source files
------------

// File: rtl/intr_pkg.sv
// Shared register map, FSM encodings and small helpers for the interrupt controller.
package intr_pkg;

  localparam logic [4:0] ADDR_MASK = 5'd8;
  localparam logic [4:0] ADDR_PEND = 5'd9;
  localparam logic [4:0] ADDR_STAT = 5'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    ILLEGAL = 2'd3
  } state_e;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
module intr_prio_enc (
  input  logic [7:0] req_i,
  output logic       valid_o,
  output logic [2:0] index_o
);

  // Priority decode, bit 0 highest
  always_comb begin
    valid_o = 1'b1;
    index_o = 3'd0;
    casez (req_i)
      8'b???????1: index_o = 3'd0;
      8'b??????10: index_o = 3'd1;
      8'b?????100: index_o = 3'd2;
      8'b????1000: index_o = 3'd3;
      8'b???10000: index_o = 3'd4;
      8'b??100000: index_o = 3'd5;
      8'b?1000000: index_o = 3'd6;
      8'b10000000: index_o = 3'd7;
      default: begin
        valid_o = 1'b0;
        index_o = 3'd0;
      end
    endcase
  end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered 8-source interrupt controller with mask/pending registers and
// a single-level request/service handshake towards the CPU.
module intr_ctrl
  import intr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] readaddr,
  output logic [7:0] readdata,
  input  logic [4:0] writeaddr,
  input  logic [7:0] writedata,
  input  logic       write_en,
  input  logic [7:0] int_src,
  output logic       irq,
  output logic [2:0] irq_vector,
  input  logic       irq_ack,
  input  logic       irq_done
);

  logic [7:0] int_src_q, mask_q, mask_d, pend_q, pend_d, rdata_q, rdata_d;
  logic       armed_q, irq_q, irq_d;
  logic [2:0] vec_q, vec_d;
  state_e     state_q, state_d;

  logic [7:0] rise_s, clr_s;
  logic       wr_mask_s, wr_pend_s, ack_s, enc_valid_s;
  logic [2:0] enc_idx_s;

  // armed_q suppresses the first cycle after reset so lines already high do not count as edges
  assign rise_s    = armed_q ? (int_src & ~int_src_q) : 8'h00;
  assign wr_mask_s = write_en && (writeaddr == ADDR_MASK);
  assign wr_pend_s = write_en && (writeaddr == ADDR_PEND);
  assign ack_s     = (state_q == REQ) && irq_ack;

  intr_prio_enc u_prio (
    .req_i   (pend_q & mask_q),
    .valid_o (enc_valid_s),
    .index_o (enc_idx_s)
  );

  // Pending/mask next state; a rising edge beats any clear in the same cycle
  always_comb begin
    clr_s  = (wr_pend_s ? writedata : 8'h00) | (ack_s ? onehot8(vec_q) : 8'h00);
    pend_d = (pend_q & ~clr_s) | rise_s;
    mask_d = wr_mask_s ? writedata : mask_q;
  end

  // Request/service FSM; the vector is latched once on entry to REQ
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (enc_valid_s) begin
          state_d = REQ;
          vec_d   = enc_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (irq_ack) state_d = SERVICE;
        else         state_d = REQ;
      end
      SERVICE: begin
        if (irq_done) state_d = IDLE;
        else          state_d = SERVICE;
      end
      default: state_d = IDLE;
    endcase
    irq_d = (state_d == REQ);
  end

  // Side-effect-free read mux
  always_comb begin
    case (readaddr)
      ADDR_MASK: rdata_d = mask_q;
      ADDR_PEND: rdata_d = pend_q;
      ADDR_STAT: rdata_d = {state_q, 3'b000, vec_q};
      default:   rdata_d = 8'h00;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_src_q <= 8'h00;
      armed_q   <= 1'b0;
      mask_q    <= 8'h00;
      pend_q    <= 8'h00;
      state_q   <= IDLE;
      irq_q     <= 1'b0;
      vec_q     <= 3'd0;
      rdata_q   <= 8'h00;
    end else begin
      int_src_q <= int_src;
      armed_q   <= 1'b1;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      irq_q     <= irq_d;
      vec_q     <= vec_d;
      rdata_q   <= rdata_d;
    end
  end

  assign readdata   = rdata_q;
  assign irq        = irq_q;
  assign irq_vector = vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: reads and irq rises are checked by a separate monitor.
module tb_intr_ctrl;

  localparam logic [4:0] A_MASK = 5'd8;
  localparam logic [4:0] A_PEND = 5'd9;
  localparam logic [4:0] A_STAT = 5'd10;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] readaddr, writeaddr;
  logic [7:0] readdata, writedata, int_src;
  logic       write_en, irq, irq_ack, irq_done;
  logic [2:0] irq_vector;

  typedef struct {string name; logic [7:0] val;} rd_exp_t;
  typedef struct {logic [2:0] vec; int cyc;} irq_exp_t;

  rd_exp_t  rd_q[$];
  irq_exp_t irq_q[$];
  int       checks = 0;
  int       errors = 0;
  int       cyc = 0;
  logic     rd_req = 1'b0;
  logic     rd_vld = 1'b0;
  logic     irq_prev = 1'b0;

  intr_ctrl dut (
    .clk(clk), .reset(reset), .readaddr(readaddr), .readdata(readdata),
    .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
    .int_src(int_src), .irq(irq), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .irq_done(irq_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected read data and expected irq rises as the DUT presents them
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) chk("rd_queue_empty", 32'd1, 32'd0);
      else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk(e.name, {24'h0, readdata}, {24'h0, e.val});
      end
    end
    if (irq && !irq_prev) begin
      if (irq_q.size() == 0) chk("unexpected_irq", {29'h0, irq_vector}, 32'hFFFF_FFFF);
      else begin
        irq_exp_t e;
        e = irq_q.pop_front();
        chk("irq_vector", {29'h0, irq_vector}, {29'h0, e.vec});
        chk("irq_latency", cyc, e.cyc);
      end
    end
    irq_prev <= irq;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string name);
    rd_exp_t e;
    e.name = name;
    e.val  = exp;
    rd_q.push_back(e);
    readaddr = a;
    rd_req   = 1'b1;
    tick();
    rd_req   = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    writeaddr = a;
    writedata = d;
    write_en  = 1'b1;
    tick();
    write_en  = 1'b0;
  endtask

  task automatic expect_irq(input logic [2:0] v, input int dly);
    irq_exp_t e;
    e.vec = v;
    e.cyc = cyc + dly;
    irq_q.push_back(e);
  endtask

  task automatic pulse_src(input logic [7:0] s);
    int_src = s;
    tick();
    int_src = 8'h00;
    tick();
  endtask

  task automatic ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic done();
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  initial begin
    reset = 1'b0; readaddr = 5'd0; writeaddr = 5'd0; writedata = 8'h00;
    write_en = 1'b0; int_src = 8'h00; irq_ack = 1'b0; irq_done = 1'b0;
    repeat (3) tick();
    chk("rst_irq", {31'h0, irq}, 32'd0);
    chk("rst_vec", {29'h0, irq_vector}, 32'd0);
    chk("rst_rdata", {24'h0, readdata}, 32'd0);
    reset = 1'b1;
    tick();
    rd(A_MASK, 8'h00, "rst_mask");
    rd(A_PEND, 8'h00, "rst_pend");
    rd(A_STAT, 8'h00, "rst_stat");
    rd(5'd3, 8'h00, "unmapped");

    // Basic request
    wr(A_MASK, 8'h01);
    expect_irq(3'd0, 2);
    pulse_src(8'h01);
    rd(A_STAT, 8'h40, "basic_stat_req");
    ack();
    rd(A_PEND, 8'h00, "basic_pend_after_ack");
    rd(A_STAT, 8'h80, "basic_stat_svc");
    done();
    rd(A_STAT, 8'h00, "basic_stat_idle");

    // Priority
    wr(A_MASK, 8'hFF);
    expect_irq(3'd2, 2);
    pulse_src(8'h24);
    rd(A_STAT, 8'h42, "prio_stat_first");
    rd(A_PEND, 8'h24, "prio_pend_both");
    ack();
    rd(A_PEND, 8'h20, "prio_pend_after_ack");
    rd(A_STAT, 8'h82, "prio_stat_svc");
    expect_irq(3'd5, 2);
    done();
    tick();
    rd(A_STAT, 8'h45, "prio_stat_second");
    ack();
    done();
    rd(A_STAT, 8'h05, "prio_stat_idle");
    rd(A_PEND, 8'h00, "prio_pend_empty");

    // Masking
    wr(A_MASK, 8'h00);
    pulse_src(8'h08);
    tick();
    rd(A_PEND, 8'h08, "mask_pend");
    rd(A_STAT, 8'h05, "mask_no_req");
    expect_irq(3'd3, 2);
    wr(A_MASK, 8'h08);
    tick();
    rd(A_STAT, 8'h43, "mask_unmask_req");
    ack();
    done();
    rd(A_PEND, 8'h00, "mask_pend_clear");

    // Set beats clear
    wr(A_MASK, 8'h00);
    int_src = 8'h02; writeaddr = A_PEND; writedata = 8'h02; write_en = 1'b1;
    tick();
    write_en = 1'b0; int_src = 8'h00;
    rd(A_PEND, 8'h02, "set_beats_clear");
    wr(A_PEND, 8'h02);
    rd(A_PEND, 8'h00, "w1c_clear");

    // Stray handshakes and vector stability
    pulse_src(8'h10);
    ack();
    rd(A_PEND, 8'h10, "stray_ack_pend");
    rd(A_STAT, 8'h03, "stray_ack_stat");
    expect_irq(3'd4, 2);
    wr(A_MASK, 8'h10);
    tick();
    done();
    rd(A_STAT, 8'h44, "stray_done_stat");
    wr(A_MASK, 8'h00);
    pulse_src(8'h01);
    rd(A_STAT, 8'h44, "vec_stable");
    rd(A_PEND, 8'h11, "stable_pend");
    ack();
    rd(A_STAT, 8'h84, "stable_svc");
    rd(A_PEND, 8'h01, "stable_pend_after_ack");

    // Reset mid-service with lines held high
    wr(A_MASK, 8'hFF);
    int_src = 8'hFF;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_irq", {31'h0, irq}, 32'd0);
    chk("midrst_rdata", {24'h0, readdata}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    rd(A_STAT, 8'h00, "midrst_stat");
    rd(A_MASK, 8'h00, "midrst_mask");
    rd(A_PEND, 8'h00, "midrst_pend");
    wr(A_MASK, 8'hFF);
    tick();
    rd(A_PEND, 8'h00, "held_high_no_pend");
    rd(A_STAT, 8'h00, "held_high_idle");
    int_src = 8'h00;
    tick();
    expect_irq(3'd2, 2);
    int_src = 8'h04;
    tick();
    tick();
    rd(A_STAT, 8'h42, "post_rst_req");
    int_src = 8'h00;
    ack();
    done();
    repeat (3) tick();

    chk("rd_queue_drained", rd_q.size(), 32'd0);
    chk("irq_queue_drained", irq_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
